instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory.
//   imem_req   : fetch outstanding (fetch unit -> memory)
//   imem_addr  : fetch address, always the current PC (fetch unit -> memory)
//   imem_ack   : memory returns imem_rdata this cycle (memory -> fetch unit)
//   imem_rdata : instruction word, valid only with imem_ack (memory -> fetch unit)
interface instr_fetch_unit_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: two-state FETCH/ISSUE controller that fetches one
// instruction at a time from instruction memory, holds it until the CPU
// retires it, then selects the next PC from the branch controls.
// Ports:
//   clk            : clock, all state updates on its rising edge
//   reset          : asynchronous active-high reset
//   imem           : instruction-memory bus (master side)
//   i_exec_done    : CPU consumed the issued instruction this cycle
//   i_bs, i_ps     : branch select / branch polarity from the decoder
//   i_z            : zero flag from the function unit
//   i_bra, i_raa   : branch target / register jump target
//   o_instr        : held instruction register
//   o_instr_valid  : o_instr is valid and awaiting i_exec_done
//   o_pc, o_pc_1   : current PC and PC+1 (wraps modulo 2^AW)
//   o_instr_count  : number of retired instructions (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 32
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  imem,
  input  logic                i_exec_done,
  input  logic [1:0]          i_bs,
  input  logic                i_ps,
  input  logic                i_z,
  input  logic [AW-1:0]       i_bra,
  input  logic [AW-1:0]       i_raa,
  output logic [31:0]         o_instr,
  output logic                o_instr_valid,
  output logic [AW-1:0]       o_pc,
  output logic [AW-1:0]       o_pc_1,
  output logic [31:0]         o_instr_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_count;
  logic [AW-1:0] w_pc_1;
  logic [AW-1:0] w_pc_next;
  logic          w_load_instr;
  logic          w_retire;
  logic          w_req;
  logic          w_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic; ack in ISSUE and exec_done in FETCH are ignored.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: if (imem.imem_ack) w_next_state = S_ISSUE;
      S_ISSUE: if (i_exec_done)   w_next_state = S_FETCH;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    w_req   = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_FETCH: w_req   = 1'b1;
      S_ISSUE: w_valid = 1'b1;
      default: w_req   = 1'b1;
    endcase
  end

  assign w_load_instr = (r_state == S_FETCH) && imem.imem_ack;
  assign w_retire     = (r_state == S_ISSUE) && i_exec_done;
  assign w_pc_1       = r_pc + AW'(1);

  // Conditional branch (BS=01) is taken when the zero flag matches polarity.
  always_comb begin
    w_pc_next = w_pc_1;
    case (i_bs)
      2'b00: w_pc_next = w_pc_1;
      2'b01: w_pc_next = (i_z == i_ps) ? i_bra : w_pc_1;
      2'b10: w_pc_next = i_raa;
      2'b11: w_pc_next = i_bra;
      default: w_pc_next = w_pc_1;
    endcase
  end

  // Datapath registers; branch inputs only matter in the retire cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC[AW-1:0];
      r_instr       <= 32'h0;
      r_instr_count <= 32'h0;
    end else begin
      if (w_load_instr) r_instr <= imem.imem_rdata;
      if (w_retire) begin
        r_pc          <= w_pc_next;
        r_instr_count <= r_instr_count + 32'd1;
      end
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign o_instr        = r_instr;
  assign o_instr_valid  = w_valid;
  assign o_pc           = r_pc;
  assign o_pc_1         = w_pc_1;
  assign o_instr_count  = r_instr_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exec_done = 1'b0;
  logic [1:0]  bs = 2'b00;
  logic        ps = 1'b0;
  logic        z = 1'b0;
  logic [31:0] bra = 32'h0;
  logic [31:0] raa = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_1;
  logic [31:0] instr_count;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 32'h0;

  instr_fetch_unit_if #(.AW(32)) imem ();

  instr_fetch_unit #(.RESET_PC(32'h0), .AW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem.master),
    .i_exec_done   (exec_done),
    .i_bs          (bs),
    .i_ps          (ps),
    .i_z           (z),
    .i_bra         (bra),
    .i_raa         (raa),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_pc_1        (pc_1),
    .o_instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = data;
    step();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic retire(input logic [1:0] b, input logic p, input logic zz,
                        input logic [31:0] ba, input logic [31:0] ra);
    bs = b; ps = p; z = zz; bra = ba; raa = ra;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    bs = 2'b00; ps = 1'b0; z = 1'b0; bra = 32'h0; raa = 32'h0;
    exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    #2;
    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_cnt", instr_count, 32'h0);
    chk("rst_req", {31'h0, imem.imem_req}, 32'h1);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    step();
    step();
    reset = 1'b0;

    // Three wait cycles then ack: address held at 0 throughout
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem.imem_addr, 32'h0);
      chk("wait_req", {31'h0, imem.imem_req}, 32'h1);
      step();
      chk("wait_valid", {31'h0, instr_valid}, 32'h0);
    end
    chk("ack_addr", imem.imem_addr, 32'h0);
    fetch(32'hA5A5_0001);
    chk("ack_instr", instr, 32'hA5A5_0001);
    chk("ack_valid", {31'h0, instr_valid}, 32'h1);
    chk("ack_req", {31'h0, imem.imem_req}, 32'h0);

    // Jump to 5, then sequential retire 5 -> 6
    retire(2'b11, 1'b0, 1'b0, 32'h5, 32'h0);
    chk("jmp5_pc", pc, 32'h5);
    fetch(32'h0000_0005);
    retire(2'b00, 1'b0, 1'b0, 32'h99, 32'h77);
    chk("seq_pc", pc, 32'h6);
    chk("seq_pc1", pc_1, 32'h7);
    chk("seq_cnt", instr_count, exp_cnt);
    chk("seq_req", {31'h0, imem.imem_req}, 32'h1);
    chk("seq_valid", {31'h0, instr_valid}, 32'h0);

    // Conditional branches from pc=8, BrA=0x20
    fetch(32'h1); retire(2'b11, 1'b0, 1'b0, 32'h8, 32'h0);
    fetch(32'h2); retire(2'b01, 1'b1, 1'b1, 32'h20, 32'h0);
    chk("br_ps1z1", pc, 32'h20);
    fetch(32'h3); retire(2'b10, 1'b0, 1'b0, 32'h0, 32'h8);
    chk("jr_back8", pc, 32'h8);
    fetch(32'h4); retire(2'b01, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("br_ps1z0", pc, 32'h9);
    fetch(32'h5); retire(2'b11, 1'b0, 1'b0, 32'h8, 32'h0);
    fetch(32'h6); retire(2'b01, 1'b0, 1'b0, 32'h20, 32'h0);
    chk("br_ps0z0", pc, 32'h20);
    fetch(32'h7); retire(2'b01, 1'b0, 1'b1, 32'h50, 32'h0);
    chk("br_ps0z1", pc, 32'h21);

    // Register jump, unconditional branch, PC wrap
    fetch(32'h8); retire(2'b10, 1'b0, 1'b0, 32'h55, 32'h1234);
    chk("jr_pc", pc, 32'h1234);
    fetch(32'h9); retire(2'b11, 1'b0, 1'b0, 32'h40, 32'h66);
    chk("jmp_pc", pc, 32'h40);
    fetch(32'hA); retire(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0);
    chk("top_pc", pc, 32'hFFFF_FFFF);
    chk("top_pc1", pc_1, 32'h0);
    fetch(32'hB); retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc1", pc_1, 32'h1);
    chk("wrap_cnt", instr_count, exp_cnt);

    // Spurious ack in ISSUE, branch inputs toggling without exec_done
    fetch(32'hCAFE_0001);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD0_BAD0;
    bs = 2'b11; bra = 32'h777;
    step();
    imem.imem_ack = 1'b0; bs = 2'b00; bra = 32'h0;
    chk("spack_instr", instr, 32'hCAFE_0001);
    chk("spack_valid", {31'h0, instr_valid}, 32'h1);
    chk("spack_pc", pc, 32'h0);
    chk("spack_cnt", instr_count, exp_cnt);
    retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ret_pc", pc, 32'h1);
    // Spurious exec_done in FETCH
    exec_done = 1'b1; bs = 2'b11; bra = 32'h99;
    step();
    exec_done = 1'b0; bs = 2'b00; bra = 32'h0;
    chk("spex_pc", pc, 32'h1);
    chk("spex_cnt", instr_count, exp_cnt);
    chk("spex_req", {31'h0, imem.imem_req}, 32'h1);
    chk("spex_instr", instr, 32'hCAFE_0001);

    // Fresh reset, build pc=0x30 / count=7, then async reset mid-ISSUE
    reset = 1'b1; #2;
    chk("rst2_cnt", instr_count, 32'h0);
    step();
    reset = 1'b0;
    exp_cnt = 32'h0;
    for (int i = 0; i < 6; i++) begin
      fetch(32'h100 + i);
      retire(2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    fetch(32'h200); retire(2'b11, 1'b0, 1'b0, 32'h30, 32'h0);
    fetch(32'h300);
    chk("pre_pc", pc, 32'h30);
    chk("pre_cnt", instr_count, 32'd7);
    chk("pre_valid", {31'h0, instr_valid}, 32'h1);
    reset = 1'b1;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h5555_AAAA;
    #2;
    chk("async_pc", pc, 32'h0);
    chk("async_cnt", instr_count, 32'h0);
    chk("async_valid", {31'h0, instr_valid}, 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_req", {31'h0, imem.imem_req}, 32'h1);
    step();
    chk("rstack_instr", instr, 32'h0);
    chk("rstack_valid", {31'h0, instr_valid}, 32'h0);
    reset = 1'b0;
    imem.imem_ack = 1'b0;
    // First edge after deassert accepts an ack
    fetch(32'h1111_2222);
    chk("post_instr", instr, 32'h1111_2222);
    chk("post_valid", {31'h0, instr_valid}, 32'h1);
    chk("post_pc", pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
